// File: rtl/dbus_uart_tx.sv
// dbus_uart_tx: memory-mapped 8N1 UART transmitter, 4-entry TX FIFO, programmable baud divisor.
// Latency: rdata one cycle after a read strobe; start bit one cycle after a DATA write to an idle block.
// Backpressure: none on the bus; a DATA write while the FIFO is full is dropped and sets sticky ovf.
// Option: define UART_TX_PARITY_EN to insert an even parity bit between DATA and STOP (11-bit frame).
module dbus_uart_tx #(
    parameter int              DW         = 16,
    parameter int              FIFO_DEPTH = 4,
    parameter logic [DW-1:0]   DIV_RST    = 16'd867
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sel,
    input  logic          we,
    input  logic [1:0]    addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] rdata,
    output logic          tx,
    output logic          irq
);

    localparam int            PW   = $clog2(FIFO_DEPTH);
    localparam int            CW   = PW + 1;
    localparam logic [DW-1:0] ONE  = 1;
    localparam logic [PW-1:0] PONE = 1;
    localparam logic [CW-1:0] CONE = 1;
`ifdef UART_TX_PARITY_EN
    localparam logic          PAR_BIT = 1'b1;
`else
    localparam logic          PAR_BIT = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [DW-1:0] div_q, div_d;
    logic [DW-1:0] baud_q, baud_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          irq_q, irq_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [DW-1:0] stat_v;

    logic wr_en, push, push_ok, pop, fifo_full, fifo_empty, bit_end;

    assign wr_en      = sel && we;
    assign push       = wr_en && (addr == 2'd0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign push_ok    = push && !fifo_full;
    assign bit_end    = (baud_q == '0);

    // Serial FSM: pops bytes from the FIFO and shifts them out as start/data/(parity)/stop bits.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        pop       = 1'b0;
        // The divisor is sampled only at bit boundaries, so DIV writes land on the next bit.
        if (state_q != S_IDLE) begin
            baud_d = bit_end ? div_q : (baud_q - ONE);
        end
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    shift_d   = mem_q[rd_ptr_q];
                    baud_d    = div_q;
                    bit_idx_d = '0;
                    state_d   = S_START;
                    tx_d      = 1'b0;
                end
            end
            S_START: begin
                if (bit_end) begin
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                    tx_d      = shift_q[0];
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = ^shift_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[bit_idx_q + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    // Back-to-back frames: go straight to START when another byte is waiting.
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_d   = mem_q[rd_ptr_q];
                        bit_idx_d = '0;
                        state_d   = S_START;
                        tx_d      = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Register file, FIFO bookkeeping and next-cycle read data / interrupt.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        div_d    = div_q;
        rdata_d  = '0;
        stat_v   = '0;
        if (push) begin
            if (fifo_full) begin
                ovf_d = 1'b1;
            end else begin
                mem_d[wr_ptr_q] = din[7:0];
                wr_ptr_d        = wr_ptr_q + PONE;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PONE;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CONE;
            2'b01:   count_d = count_q - CONE;
            default: count_d = count_q;
        endcase
        if (wr_en && (addr == 2'd1) && din[3]) begin
            ovf_d = 1'b0;
        end
        if (wr_en && (addr == 2'd2)) begin
            div_d = din;
        end
        // Reads report the state as it stands after this edge.
        stat_v[0] = (count_d == CW'(FIFO_DEPTH));
        stat_v[1] = (count_d == '0);
        stat_v[2] = (state_d != S_IDLE);
        stat_v[3] = ovf_d;
        stat_v[4] = PAR_BIT;
        if (sel && !we) begin
            case (addr)
                2'd1:    rdata_d = stat_v;
                2'd2:    rdata_d = div_d;
                default: rdata_d = '0;
            endcase
        end
        irq_d = (count_d == '0) && (state_d == S_IDLE);
    end

    // FIFO storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // State registers; reset aborts any frame and forces the line idle-high immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            div_q     <= DIV_RST;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            irq_q     <= 1'b1;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            div_q     <= div_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            irq_q     <= irq_d;
            rdata_q   <= rdata_d;
        end
    end

    assign rdata = rdata_q;
    assign tx    = tx_q;
    assign irq   = irq_q;

endmodule

// File: tb/tb_dbus_uart_tx.sv
// tb_dbus_uart_tx: randomized scoreboard bench for dbus_uart_tx against a frame-timing reference model.
// Latency: model predicts each frame's first start-bit cycle and every bit cycle of the line.
// Backpressure: model predicts FIFO drops (overflow) from occupancy at each write edge.
module tb_dbus_uart_tx;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int   NB  = 11;
    localparam logic PAR = 1'b1;
`else
    localparam int   NB  = 10;
    localparam logic PAR = 1'b0;
`endif

    logic          clk  = 1'b0;
    logic          rst  = 1'b0;
    logic          sel  = 1'b0;
    logic          we   = 1'b0;
    logic [1:0]    addr = '0;
    logic [DW-1:0] din  = '0;
    logic [DW-1:0] rdata;
    logic          tx;
    logic          irq;

    dbus_uart_tx #(.DW(DW), .FIFO_DEPTH(DEPTH), .DIV_RST(16'd867)) dut (
        .clk(clk), .rst(rst), .sel(sel), .we(we), .addr(addr), .din(din),
        .rdata(rdata), .tx(tx), .irq(irq)
    );

    always #5 clk = ~clk;

    // Edge counter: at a negedge, cyc is the index of the posedge just passed.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] b;
        int         s;
        int         l;
    } exp_t;

    exp_t expq[$];
    int   acc_w[$];
    int   acc_s[$];
    int   acc_e[$];
    int   mdiv   = 867;
    logic movf   = 1'b0;
    bit   mon_en = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, got, exp, cyc);
    endtask

    // Bytes held in the FIFO just after edge e: accepted writes minus pops so far.
    function automatic int count_after(input int e);
        int c = 0;
        for (int i = 0; i < acc_w.size(); i++) begin
            if (acc_w[i] <= e) c++;
            if (acc_s[i] <= e) c--;
        end
        return c;
    endfunction

    function automatic bit busy_after(input int e);
        for (int i = 0; i < acc_s.size(); i++)
            if (acc_s[i] <= e && e < acc_e[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] exp_stat(input int e);
        logic [15:0] r = '0;
        int c = count_after(e);
        r[0] = (c == DEPTH);
        r[1] = (c == 0);
        r[2] = busy_after(e);
        r[3] = movf;
        r[4] = PAR;
        return r;
    endfunction

    // Line value during frame bit k: start, 8 data LSB first, optional even parity, stop.
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
        if (NB == 11 && k == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic bus_wr(input logic [1:0] a, input logic [15:0] d, output int e);
        sel = 1'b1; we = 1'b1; addr = a; din = d;
        @(negedge clk);
        e = cyc;
        sel = 1'b0; we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [15:0] v, output int e);
        sel = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        e = cyc; v = rdata;
        sel = 1'b0;
    endtask

    // Bus write plus reference-model update.
    task automatic ui_wr(input logic [1:0] a, input logic [15:0] d);
        int n, s;
        bus_wr(a, d, n);
        if (a == 2'd0) begin
            if (count_after(n - 1) < DEPTH) begin
                s = n + 1;
                if (acc_e.size() > 0 && acc_e[$] > s) s = acc_e[$];
                acc_w.push_back(n);
                acc_s.push_back(s);
                acc_e.push_back(s + NB * (mdiv + 1));
                expq.push_back('{b: d[7:0], s: s, l: mdiv + 1});
            end else begin
                movf = 1'b1;
            end
        end else if (a == 2'd1) begin
            if (d[3]) movf = 1'b0;
        end else if (a == 2'd2) begin
            mdiv = int'(d);
        end
    endtask

    task automatic chk_stat(input string nm);
        logic [15:0] v;
        int e;
        rd(2'd1, v, e);
        chk(nm, v, exp_stat(e));
    endtask

    task automatic drain(input string nm);
        int budget = 0;
        while ((expq.size() > 0 || (acc_e.size() > 0 && cyc < acc_e[$])) && budget < 20000) begin
            @(negedge clk);
            budget++;
        end
        chk({nm, "_pending"}, expq.size(), 0);
        chk({nm, "_irq"}, irq, 1'b1);
        chk({nm, "_tx_idle"}, tx, 1'b1);
    endtask

    // Monitor: on each start bit, pop the scoreboard and check start cycle and every bit cycle.
    initial begin : monitor
        logic prev;
        exp_t x;
        int   bad, s_obs;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst && mon_en && prev === 1'b1 && tx === 1'b0) begin
                s_obs = cyc;
                if (expq.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_frame: start at cycle %0d, none expected", s_obs);
                end else begin
                    x = expq.pop_front();
                    bad = 0;
                    for (int j = 0; j < NB * x.l; j++) begin
                        if (j > 0) @(negedge clk);
                        if (tx !== frame_bit(x.b, j / x.l)) bad++;
                    end
                    n_chk++;
                    if (s_obs == x.s && bad == 0) n_pass++;
                    else $display("FAIL frame %h: start cycle %0d expected %0d, %0d wrong bit-cycles expected 0",
                                  x.b, s_obs, x.s, bad);
                end
            end
            prev = tx;
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

    initial begin : stim
        logic [15:0] v;
        logic [7:0]  b;
        int n, e, len, bad;

        // Reset
        repeat (2) @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_irq", irq, 1'b1);
        chk("rst_rdata", rdata, 16'h0000);
        rst = 1'b1;
        @(negedge clk);
        chk_stat("rst_stat");
        rd(2'd2, v, e);
        chk("rst_div", v, 16'd867);
        rd(2'd0, v, e);
        chk("data_reads_zero", v, 16'h0000);

        // Single frame, DIV=3
        ui_wr(2'd2, 16'd3);
        rd(2'd2, v, e);
        chk("div_readback", v, 16'd3);
        ui_wr(2'd0, 16'h0055);
        chk("irq_low_after_write", irq, 1'b0);
        while (cyc < acc_e[$] - 1) @(negedge clk);
        chk("irq_low_in_stop", irq, 1'b0);
        @(negedge clk);
        chk("irq_high_after_stop", irq, 1'b1);
        drain("single");

        // Three back-to-back frames, STAT sampled mid-stream
        ui_wr(2'd0, 16'h00A1);
        ui_wr(2'd0, 16'h000F);
        ui_wr(2'd0, 16'h00FF);
        for (int i = 0; i < 4; i++) begin
            repeat (25) @(negedge clk);
            chk_stat("b2b_stat_busy");
        end
        drain("b2b");

        // Overflow: DIV=100, six consecutive writes, sixth dropped
        ui_wr(2'd2, 16'd100);
        for (int i = 0; i < 6; i++) ui_wr(2'd0, 16'($urandom_range(0, 255)));
        chk_stat("full_ovf_stat");
        ui_wr(2'd1, 16'h0008);
        chk_stat("ovf_cleared_stat");
        drain("ovf");

        // DIV change mid-bit: 8-cycle start bit, then 2-cycle bits
        ui_wr(2'd2, 16'd7);
        mon_en = 1'b0;
        b = 8'($urandom_range(0, 255));
        bus_wr(2'd0, {8'h00, b}, n);
        len = 8 + (NB - 1) * 2;
        bad = 0;
        @(negedge clk);
        for (int c = n + 1; c < n + 1 + len; c++) begin
            if (c - n - 1 < 8) begin
                if (tx !== 1'b0) bad++;
            end else if (tx !== frame_bit(b, 1 + (c - n - 1 - 8) / 2)) bad++;
            if (c == n + 3) begin
                sel = 1'b1; we = 1'b1; addr = 2'd2; din = 16'd1;
            end else begin
                sel = 1'b0; we = 1'b0;
            end
            @(negedge clk);
        end
        chk("div_midbit_trace_errors", bad, 0);
        chk("div_midbit_irq_end", irq, 1'b1);
        mdiv = 1;
        mon_en = 1'b1;

        // DIV=0, byte 0x07: one cycle per bit, parity bit 1 when enabled
        ui_wr(2'd2, 16'd0);
        ui_wr(2'd0, 16'h0007);
        drain("div0");

        // Randomized batches with random DIV, gaps and STAT reads
        for (int bt = 0; bt < 3; bt++) begin
            ui_wr(2'd2, 16'($urandom_range(0, 4)));
            ui_wr(2'd1, 16'h0008);
            for (int i = 0; i < 8; i++) begin
                ui_wr(2'd0, 16'($urandom_range(0, 255)));
                repeat ($urandom_range(0, 12)) @(negedge clk);
                if ($urandom_range(0, 3) == 0) chk_stat("rand_stat_mid");
            end
            drain("rand");
            chk_stat("rand_stat_end");
        end

        // Reset mid-frame: line goes high at once, FIFO discarded, DIV back to reset value
        ui_wr(2'd2, 16'd3);
        mon_en = 1'b0;
        bus_wr(2'd0, 16'h0000, n);
        bus_wr(2'd0, 16'h0000, n);
        repeat (6) @(negedge clk);
        chk("pre_rst_tx_low", tx, 1'b0);
        #2 rst = 1'b0;
        #1 chk("async_rst_tx_high", tx, 1'b1);
        @(negedge clk);
        chk("rst_mid_irq", irq, 1'b1);
        rst = 1'b1;
        expq.delete(); acc_w.delete(); acc_s.delete(); acc_e.delete();
        mdiv = 867; movf = 1'b0;
        chk_stat("post_rst_stat");
        rd(2'd2, v, e);
        chk("post_rst_div", v, 16'd867);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx !== 1'b1) bad++;
        end
        chk("post_rst_line_idle", bad, 0);
        mon_en = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dbus_uart_tx.md
Name: dbus_uart_tx

Overview:
- Memory-mapped UART transmitter on the downstream side of dbus.
- dbus decodes its address window and forwards sel/we/addr/din to this block; this block returns rdata, which dbus muxes onto dout.
- CPU stores bytes into a 4-entry TX FIFO; a bit-serial FSM drains the FIFO onto tx, 8N1 framing, programmable baud divisor.

Parameters:
- DW, 16, bus data width; must be 16 or more.
- FIFO_DEPTH, 4, TX FIFO entries; must be a power of 2, at least 2.
- DIV_RST, 16'd867, reset value of the DIV register (cycles per bit minus 1).

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset).
- sel  input  1  block selected by dbus decode this cycle.
- we  input  1  write strobe; qualified by sel.
- addr  input  2  register word offset.
- din  input  DW  write data.
- rdata  output  DW  registered read data.
- tx  output  1  serial line; idle high.
- irq  output  1  level interrupt: FIFO empty and FSM idle.

Behaviour:
- Register map (addr):
  - 0 DATA: a write pushes din[7:0]; reads return 0.
  - 1 STAT: read bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 ovf (sticky); other bits 0. Writing 1 to din[3] clears ovf; other bits are ignored.
  - 2 DIV: read/write, full DW bits.
  - 3: reserved; reads return 0, writes are ignored.
- Read timing:
  - When sel=1 and we=0 at edge N, rdata holds the register value from after edge N.
  - When sel=0 or we=1, rdata is cleared to 0 at the edge.
- Reset values: rdata=0, tx=1, irq=1, FIFO empty, ovf=0, DIV=DIV_RST, FSM=IDLE, bit counter=0.
- Reset asserted mid-frame aborts the frame; tx returns high asynchronously and FIFO contents are discarded.
- FIFO:
  - count width is clog2(FIFO_DEPTH)+1; read/write pointers wrap modulo FIFO_DEPTH.
  - A push while full (full evaluated before this edge) is dropped and sets ovf. This holds even if a pop occurs in the same cycle.
  - Push and pop in the same cycle while not full: count unchanged, both pointers advance.
- FSM states: IDLE, START, DATA, STOP (plus PARITY, see below).
  - IDLE: if FIFO not empty, pop into an 8-bit shift register, load baud counter with DIV, go to START.
  - Write at edge N into an empty FIFO with FSM IDLE: pop at edge N+1, tx=0 from edge N+1.
- Bit timing:
  - Every bit lasts DIV+1 cycles.
  - Baud counter decrements each cycle; at 0 it reloads from the current DIV and the FSM advances.
  - A DIV write mid-frame takes effect at the next bit boundary.
  - DIV=0 gives 1 cycle per bit.
- Frame:
  - START drives tx=0, then DATA.
  - DATA sends the shift register LSB first for 8 bits; a bit index counts 0..7.
  - STOP drives tx=1 for one bit time.
- STOP exit:
  - FIFO not empty: pop directly into START with no idle gap (back-to-back frames).
  - FIFO empty: go to IDLE.
- tx is a registered output: no combinational path from FIFO or registers.
- irq = empty and FSM==IDLE, registered.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: PARITY state between DATA and STOP sends even parity (XOR of the 8 data bits) for one bit time; frame is 11 bits. STAT bit4 reads 1.
- Undefined: no PARITY state; 10-bit frame; STAT bit4 reads 0.

Test Plan:
- Reset: rst=0 for 2 cycles -> tx=1, irq=1, STAT reads 16'h0002, DIV reads 16'd867.
- DIV=3, write DATA=8'h55 -> tx=0 one cycle after the write edge. Then 4-cycle bits 1,0,1,0,1,0,1,0, then stop=1; 40 cycles total; irq returns 1 after STOP.
- DIV=3, write 8'hA1, 8'h0F, 8'hFF back-to-back -> three contiguous frames, no idle cycles between stop and start, 120 cycles total. STAT busy=1 throughout.
- DIV=100, write 5 bytes in consecutive cycles -> first pops immediately. The 5th write fills the FIFO (full=1), so the write order and FIFO depth must be checked together. A 6th write sets ovf=1 (STAT bit3) and is not transmitted; writing STAT din=16'h0008 clears ovf.
- Write DIV=1 mid-bit with DIV=7 -> current bit completes with 8 cycles, following bits take 2 cycles.
- With UART_TX_PARITY_EN, DIV=0, byte 8'h07 -> 11-cycle frame, parity bit=1. Without the macro -> 10-cycle frame.
